alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of per-requester grant counters.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 req0_valid_i / req1_valid_i  input  1 each  requester k has an operation pending.
REQ-005 req0_ready_o / req1_ready_o  output  1 each  operation of requester k accepted this cycle.
REQ-006 req0_a_i, req0_b_i / req1_a_i, req1_b_i  input  32 each  operands of requester k.
REQ-007 req0_op_i / req1_op_i  input  4 each  ALU op code of requester k.
REQ-008 rsp_valid_o  output  1  response register holds a result.
REQ-009 rsp_ready_i  input  1  consumer takes the response this cycle.
REQ-010 rsp_id_o  output  1  requester index owning the response.
REQ-011 rsp_result_o  output  32  registered ALU result.
REQ-012 rsp_zero_o  output  1  registered zero flag.
REQ-013 rsp_err_o  output  1  op code was not one of AND 0000, OR 0001, ADD 0010, SUB 0110.
REQ-014 grant0_cnt_o / grant1_cnt_o  output  CNT_W each  accepted-operation counts.

Function
REQ-015 One shared ALU instance; at most one operation accepted per cycle.
REQ-016 Two states: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
REQ-017 Slot free when state EMPTY, or FULL with rsp_ready_i=1 (same-cycle drain and refill).
REQ-018 Accept only when the slot is free and at least one valid is high; ready asserted combinationally to exactly the winner, never to both.
REQ-019 Round-robin: pointer prio selects the preferred requester; if only one valid, it wins regardless of prio.
REQ-020 After every accept, prio becomes the requester not granted; with no accept, prio holds.
REQ-021 Latency: accepted operation appears on rsp_* on the next rising edge (1 cycle).
REQ-022 Result captured = ALU output of winner's a, b, op; zero = (result == 0).
REQ-023 Illegal op: accepted normally, rsp_result_o=0, rsp_zero_o=1, rsp_err_o=1; legal op: rsp_err_o=0.
REQ-024 rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-025 FULL with rsp_ready_i=1 and no valid -> EMPTY; FULL with rsp_ready_i=0 -> FULL, all ready low.
REQ-026 Grant counters increment by 1 per accept of that requester; saturate at all-ones, no wrap.
REQ-027 No combinational path from rsp_ready_i to rsp_* outputs; ready_o may depend on rsp_ready_i.

Reset
REQ-028 On rst_i high (any time, incl. mid-transfer): state EMPTY, rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_err_o=0, prio=requester 0, both counters 0.
REQ-029 While rst_i high both ready_o are 0; pending response discarded, not replayed.

Structure
REQ-030 Op-code constants (AND, OR, ADD, SUB) and the state enum live in a shared package alu_pkg.
REQ-031 Sole sub-module: one instance of the existing ALU block; arbitration and registers in alu_arbiter.

Verification
REQ-032 Single: req0 a=5 b=3 op=0010 -> next cycle rsp_valid=1 id=0 result=8 zero=0 err=0.
REQ-033 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; after 4 cycles each counter=2.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles with FULL -> both ready low, rsp_* unchanged; release -> same-cycle refill.
REQ-035 Zero/illegal: req1 a=7 b=7 op=0110 -> result=0 zero=1; op=1111 -> result=0 zero=1 err=1.
REQ-036 Saturation: CNT_W=2, 5 accepts from req0 -> grant0_cnt_o=3.
REQ-037 Reset mid-operation: assert rst_i while FULL -> rsp_valid_o=0 immediately, prio=0; first post-reset contention grants req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op-code constants, response-slot state
// encoding, and a helper that classifies op codes as legal or illegal.
// No logic of its own; no latency or backpressure applies.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;

   // Response slot occupancy. ST_FULL means rsp_* holds a result.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose: 32-bit combinational ALU (AND/OR/ADD/SUB) with zero and illegal-op flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to capture the outputs.
// Ports: a, b operands; op code; result, zero = (result == 0), err = illegal op.
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result,
   output logic        zero,
   output logic        err
);

   always_comb begin
      result = '0;
      err    = !op_legal(op);
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         default: result = '0;   // illegal ops yield 0, which also forces zero=1
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter letting two requesters share one ALU, with a single
//          registered response slot and saturating per-requester grant counters.
// Latency: 1 cycle from accept (valid & ready) to result on rsp_*.
// Backpressure: slot refills in the same cycle it drains; with rsp_ready_i low and the
//          slot full, both ready outputs stay low and rsp_* hold.
// Ports: clk_i, rst_i (async, active high); req{0,1}_{valid_i,ready_o,a_i,b_i,op_i};
//        rsp_{valid_o,ready_i,id_o,result_o,zero_o,err_o}; grant{0,1}_cnt_o.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [31:0]      req0_a_i,
   input  logic [31:0]      req0_b_i,
   input  logic [3:0]       req0_op_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [31:0]      req1_a_i,
   input  logic [31:0]      req1_b_i,
   input  logic [3:0]       req1_op_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_id_o,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_zero_o,
   output logic             rsp_err_o,
   output logic [CNT_W-1:0] grant0_cnt_o,
   output logic [CNT_W-1:0] grant1_cnt_o
);

   state_t      state, state_nxt;
   logic        prio;        // preferred requester when both are valid
   logic        slot_free;
   logic        grant1;      // 1: requester 1 wins this cycle
   logic        accept;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero, alu_err;

   // Next-state / handshake logic.
   always_comb begin
      state_nxt    = state;
      slot_free    = (state == ST_EMPTY) || rsp_ready_i;
      grant1       = (req0_valid_i && req1_valid_i) ? prio : req1_valid_i;
      // Reset is async, so gate ready here too: nothing may be accepted while rst_i is high.
      accept       = !rst_i && slot_free && (req0_valid_i || req1_valid_i);
      req0_ready_o = accept && !grant1;
      req1_ready_o = accept && grant1;
      if (accept) begin
         state_nxt = ST_FULL;
      end else if ((state == ST_FULL) && rsp_ready_i) begin
         state_nxt = ST_EMPTY;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   assign rsp_valid_o = (state == ST_FULL);

   assign alu_a  = grant1 ? req1_a_i  : req0_a_i;
   assign alu_b  = grant1 ? req1_b_i  : req0_b_i;
   assign alu_op = grant1 ? req1_op_i : req0_op_i;

   alu_arbiter_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_result),
      .zero   (alu_zero),
      .err    (alu_err)
   );

   // Response registers, priority pointer and grant counters only move on accept,
   // which keeps rsp_* stable under backpressure.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_id_o     <= 1'b0;
         rsp_result_o <= '0;
         rsp_zero_o   <= 1'b0;
         rsp_err_o    <= 1'b0;
         prio         <= 1'b0;
         grant0_cnt_o <= '0;
         grant1_cnt_o <= '0;
      end else if (accept) begin
         rsp_id_o     <= grant1;
         rsp_result_o <= alu_result;
         rsp_zero_o   <= alu_zero;
         rsp_err_o    <= alu_err;
         prio         <= !grant1;
         if (!grant1 && (grant0_cnt_o != '1)) begin
            grant0_cnt_o <= grant0_cnt_o + CNT_W'(1);
         end
         if (grant1 && (grant1_cnt_o != '1)) begin
            grant1_cnt_o <= grant1_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule
